bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_arbiter_if.sv | 14 +
 rtl/bus_timer.sv | 25 ++
 rtl/bus_arbiter.sv | 84 ++++++++
 tb/tb_bus_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared state and owner encodings for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10,
    TURN = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_M1   = 2'b01,
    OWNER_M2   = 2'b10
  } owner_t;

  function automatic owner_t owner_of(input state_t s);
    case (s)
      OWN1:    return OWNER_M1;
      OWN2:    return OWNER_M2;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters and the arbiter.
interface bus_arbiter_if;
  logic       m1_request;
  logic       m2_request;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] bus_owner;
  logic       timeout;

  modport master (output m1_request, m2_request,
                  input  m1_grant, m2_grant, bus_owner, timeout);
  modport slave  (input  m1_request, m2_request,
                  output m1_grant, m2_grant, bus_owner, timeout);
endinterface

// File: rtl/bus_timer.sv
// Tenure counter: clears outside a tenure, counts up while one runs, saturates at TIMEOUT.
module bus_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)              cnt <= '0;
    else if (!run)           cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // Fires in the last permitted grant cycle so the grant drops on the following edge.
  assign expire = (TIMEOUT != 0) && run && (cnt == CNT_LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with tenure timeout and a one-cycle turnaround between owners.
// Define ROUND_ROBIN_EN to break ties in favour of the master that did not own the bus last.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  state_t state, state_nxt;
  logic   timeout_nxt;
  logic   expire;
  logic   m1_wins_tie;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    ((state == OWN1) || (state == OWN2)),
    .expire (expire)
  );

`ifdef ROUND_ROBIN_EN
  owner_t last_owner;

  always_ff @(posedge clk) begin
    if (!reset)                 last_owner <= OWNER_M2;
    else if (state_nxt == OWN1) last_owner <= OWNER_M1;
    else if (state_nxt == OWN2) last_owner <= OWNER_M2;
  end

  assign m1_wins_tie = (last_owner != OWNER_M1);
`else
  assign m1_wins_tie = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (bus.m1_request && bus.m2_request) state_nxt = m1_wins_tie ? OWN1 : OWN2;
        else if (bus.m1_request)              state_nxt = OWN1;
        else if (bus.m2_request)              state_nxt = OWN2;
        else                                  state_nxt = IDLE;
      end
      OWN1: begin
        if (!bus.m1_request) state_nxt = TURN;
        else if (expire) begin
          state_nxt   = TURN;
          timeout_nxt = 1'b1;
        end
      end
      OWN2: begin
        if (!bus.m2_request) state_nxt = TURN;
        else if (expire) begin
          state_nxt   = TURN;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so grants appear one edge after the request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bus.m1_grant  <= 1'b0;
      bus.m2_grant  <= 1'b0;
      bus.bus_owner <= OWNER_NONE;
      bus.timeout   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.m1_grant  <= (state_nxt == OWN1);
      bus.m2_grant  <= (state_nxt == OWN2);
      bus.bus_owner <= owner_of(state_nxt);
      bus.timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: instance A uses TIMEOUT=15, instance B uses TIMEOUT=4.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus_a ();
  bus_arbiter_if bus_b ();

  bus_arbiter #(.TIMEOUT(15)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  bus_arbiter #(.TIMEOUT(4))  u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // {m1_grant, m2_grant, bus_owner, timeout}
  localparam logic [4:0] O_NONE = 5'b00_00_0;
  localparam logic [4:0] O_M1   = 5'b10_01_0;
  localparam logic [4:0] O_M2   = 5'b01_10_0;
  localparam logic [4:0] O_TO   = 5'b00_00_1;

  function automatic logic [4:0] outs_a();
    return {bus_a.m1_grant, bus_a.m2_grant, bus_a.bus_owner, bus_a.timeout};
  endfunction

  function automatic logic [4:0] outs_b();
    return {bus_b.m1_grant, bus_b.m2_grant, bus_b.bus_owner, bus_b.timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later; grant exclusivity checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("excl_a", 32'(bus_a.m1_grant & bus_a.m2_grant), 32'd0);
    chk("excl_b", 32'(bus_b.m1_grant & bus_b.m2_grant), 32'd0);
  endtask

  initial begin
    logic [4:0] second;
    reset = 1'b0;
    bus_a.m1_request = 1'b1;
    bus_a.m2_request = 1'b1;
    bus_b.m1_request = 1'b0;
    bus_b.m2_request = 1'b0;

    // Reset held with both requests active
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", 32'(outs_a()), 32'(O_NONE));
    end
    reset = 1'b1;
    step();
    chk("rst_release_m1", 32'(outs_a()), 32'(O_M1));
    bus_a.m1_request = 1'b0;
    bus_a.m2_request = 1'b0;
    step();
    chk("rst_turn", 32'(outs_a()), 32'(O_NONE));
    step();
    chk("rst_idle", 32'(outs_a()), 32'(O_NONE));

    // Single master for four cycles
    bus_a.m2_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_m2", 32'(outs_a()), 32'(O_M2));
    end
    bus_a.m2_request = 1'b0;
    step();
    chk("single_turn", 32'(outs_a()), 32'(O_NONE));
    step();
    chk("single_idle", 32'(outs_a()), 32'(O_NONE));

    // Contention: m1 wins, m2 pending until m1 releases
    bus_a.m1_request = 1'b1;
    bus_a.m2_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cont_m1", 32'(outs_a()), 32'(O_M1));
    end
    bus_a.m1_request = 1'b0;
    step();
    chk("cont_turn", 32'(outs_a()), 32'(O_NONE));
    step();
    chk("cont_m2", 32'(outs_a()), 32'(O_M2));
    bus_a.m2_request = 1'b0;
    step();
    chk("cont_turn2", 32'(outs_a()), 32'(O_NONE));
    step();
    chk("cont_idle", 32'(outs_a()), 32'(O_NONE));

    // Timeout: 15-cycle tenure, one-cycle pulse in TURN, then regrant
    bus_a.m1_request = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("to_m1_%0d", i), 32'(outs_a()), 32'(O_M1));
    end
    step();
    chk("to_pulse", 32'(outs_a()), 32'(O_TO));
    step();
    chk("to_regrant", 32'(outs_a()), 32'(O_M1));
    bus_a.m1_request = 1'b0;
    step();
    chk("to_turn", 32'(outs_a()), 32'(O_NONE));
    step();
    chk("to_idle", 32'(outs_a()), 32'(O_NONE));

    // Mid-tenure reset during OWN2
    bus_a.m2_request = 1'b1;
    step();
    chk("mr_m2", 32'(outs_a()), 32'(O_M2));
    step();
    chk("mr_m2b", 32'(outs_a()), 32'(O_M2));
    reset = 1'b0;
    step();
    chk("mr_drop", 32'(outs_a()), 32'(O_NONE));
    reset = 1'b1;
    bus_a.m1_request = 1'b1;
    step();
    chk("mr_rearb_m1", 32'(outs_a()), 32'(O_M1));
    bus_a.m1_request = 1'b0;
    bus_a.m2_request = 1'b0;
    step();
    chk("mr_turn", 32'(outs_a()), 32'(O_NONE));

    // Instance B: both held with TIMEOUT=4
`ifdef ROUND_ROBIN_EN
    second = O_M2;
`else
    second = O_M1;
`endif
    bus_b.m1_request = 1'b1;
    bus_b.m2_request = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        step();
        chk($sformatf("alt_%0d_%0d", t, i), 32'(outs_b()), (t == 1) ? 32'(second) : 32'(O_M1));
      end
      step();
      chk($sformatf("alt_to_%0d", t), 32'(outs_b()), 32'(O_TO));
    end
    bus_b.m1_request = 1'b0;
    bus_b.m2_request = 1'b0;
    step();
    chk("alt_idle", 32'(outs_b()), 32'(O_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
